// File: rtl/qk_core_sequencer.sv
// Per-core sequencer for one fullchip QK core: host Q/K writes, K load, execute, ofifo drain.
// Optional build macro PMEM_READBACK_EN adds an RDBK state that reads pmem back after MOVE.
module qk_core_sequencer #(
  parameter int unsigned bw          = 4,
  parameter int unsigned pr          = 8,
  parameter int unsigned col         = 8,
  parameter int unsigned total_cycle = 8,
  parameter int unsigned gap         = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [pr*bw-1:0] i_host_data,
  input  logic             i_host_valid,
  output logic             o_host_ready,
  output logic [pr*bw-1:0] o_mem_in,
  output logic [16:0]      o_inst,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_phase
);

  localparam int unsigned CntW = 8;

  localparam int unsigned BitOfifoRd = 16;
  localparam int unsigned QkAddLsb   = 12;
  localparam int unsigned PAddLsb    = 8;
  localparam int unsigned BitExecute = 7;
  localparam int unsigned BitLoad    = 6;
  localparam int unsigned BitQmemRd  = 5;
  localparam int unsigned BitQmemWr  = 4;
  localparam int unsigned BitKmemRd  = 3;
  localparam int unsigned BitKmemWr  = 2;
`ifdef PMEM_READBACK_EN
  localparam int unsigned BitPmemRd  = 1;
`endif
  localparam int unsigned BitPmemWr  = 0;

  localparam logic [CntW-1:0] QLast   = CntW'(total_cycle - 1);
  localparam logic [CntW-1:0] KLast   = CntW'(col - 1);
  localparam logic [CntW-1:0] LdLast  = CntW'(col);
  localparam logic [CntW-1:0] GapLast = CntW'(gap - 1);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StQwr    = 4'd1,
    StKwr    = 4'd2,
    StLoad   = 4'd3,
    StLdrain = 4'd4,
    StGap1   = 4'd5,
    StExec   = 4'd6,
    StGap2   = 4'd7,
    StMove   = 4'd8,
`ifdef PMEM_READBACK_EN
    StRdbk   = 4'd9,
`endif
    StDone   = 4'd10
  } state_e;

  state_e             r_state, w_state_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic [16:0]        r_inst, w_inst_d;
  logic [pr*bw-1:0]   r_mem_in, w_mem_in_d;
  logic               w_beat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_inst   <= '0;
      r_mem_in <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_inst   <= w_inst_d;
      r_mem_in <= w_mem_in_d;
    end
  end

  assign o_host_ready = (r_state == StQwr) || (r_state == StKwr);
  assign w_beat       = o_host_ready & i_host_valid;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_inst_d   = '0;
    w_mem_in_d = r_mem_in;

    // abort beats every other request, including a start in the same cycle
    if (i_abort) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_d = StQwr;
            w_cnt_d   = '0;
          end
        end

        StQwr, StKwr: begin
          // stalled cycles keep the last address on the bus with no write strobe
          w_inst_d[QkAddLsb +: 4] = r_inst[QkAddLsb +: 4];
          if (w_beat) begin
            w_inst_d[QkAddLsb +: 4] = r_cnt[3:0];
            w_mem_in_d              = i_host_data;
            w_cnt_d                 = r_cnt + CntW'(1);
            if (r_state == StQwr) begin
              w_inst_d[BitQmemWr] = 1'b1;
              if (r_cnt == QLast) begin
                w_state_d = StKwr;
                w_cnt_d   = '0;
              end
            end else begin
              w_inst_d[BitKmemWr] = 1'b1;
              if (r_cnt == KLast) begin
                w_state_d = StLoad;
                w_cnt_d   = '0;
              end
            end
          end
        end

        StLoad: begin
          // cycle 0 primes the array; cycles 1..col stream kmem rows 0..col-1
          w_inst_d[BitLoad] = 1'b1;
          if (r_cnt != '0) begin
            w_inst_d[BitKmemRd]     = 1'b1;
            w_inst_d[QkAddLsb +: 4] = r_cnt[3:0] - 4'd1;
          end
          w_cnt_d = r_cnt + CntW'(1);
          if (r_cnt == LdLast) begin
            w_state_d = StLdrain;
            w_cnt_d   = '0;
          end
        end

        StLdrain: begin
          w_inst_d[BitLoad] = 1'b1;
          w_state_d         = StGap1;
          w_cnt_d           = '0;
        end

        StGap1, StGap2: begin
          w_cnt_d = r_cnt + CntW'(1);
          if (r_cnt == GapLast) begin
            w_state_d = (r_state == StGap1) ? StExec : StMove;
            w_cnt_d   = '0;
          end
        end

        StExec: begin
          w_inst_d[BitExecute]    = 1'b1;
          w_inst_d[BitQmemRd]     = 1'b1;
          w_inst_d[QkAddLsb +: 4] = r_cnt[3:0];
          w_cnt_d                 = r_cnt + CntW'(1);
          if (r_cnt == QLast) begin
            w_state_d = StGap2;
            w_cnt_d   = '0;
          end
        end

        StMove: begin
          w_inst_d[BitOfifoRd]   = 1'b1;
          w_inst_d[BitPmemWr]    = 1'b1;
          w_inst_d[PAddLsb +: 4] = r_cnt[3:0];
          w_cnt_d                = r_cnt + CntW'(1);
          if (r_cnt == QLast) begin
`ifdef PMEM_READBACK_EN
            w_state_d = StRdbk;
`else
            w_state_d = StDone;
`endif
            w_cnt_d   = '0;
          end
        end

`ifdef PMEM_READBACK_EN
        StRdbk: begin
          w_inst_d[BitPmemRd]    = 1'b1;
          w_inst_d[PAddLsb +: 4] = r_cnt[3:0];
          w_cnt_d                = r_cnt + CntW'(1);
          if (r_cnt == QLast) begin
            w_state_d = StDone;
            w_cnt_d   = '0;
          end
        end
`endif

        StDone: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end

        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_inst   = r_inst;
  assign o_mem_in = r_mem_in;
  assign o_busy   = (r_state != StIdle);
  assign o_done   = (r_state == StDone);
  assign o_phase  = r_state;

endmodule

// File: tb/tb_qk_core_sequencer.sv
// Scoreboard bench for qk_core_sequencer: directed runs push cycle-stamped expected inst words,
// a negedge monitor pops and compares every nonzero inst and every done pulse.
module tb_qk_core_sequencer;

  localparam int TC  = 8;
  localparam int COL = 8;
  localparam int GAP = 10;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          host_valid = 1'b0;
  logic [DW-1:0] host_data = '0;
  logic          host_ready;
  logic [DW-1:0] mem_in;
  logic [16:0]   inst;
  logic          busy;
  logic          done;
  logic [3:0]    phase;

  always #5 clk = ~clk;

  qk_core_sequencer #(
    .bw(4), .pr(8), .col(COL), .total_cycle(TC), .gap(GAP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_host_data(host_data), .i_host_valid(host_valid), .o_host_ready(host_ready),
    .o_mem_in(mem_in), .o_inst(inst), .o_busy(busy), .o_done(done), .o_phase(phase)
  );

  typedef struct {
    int            cyc;
    logic [16:0]   inst;
    logic [DW-1:0] mem;
    bit            chk;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bl = 1, bh = 0, rl = 1, rh = 0;
  logic [3:0] ph_end = 4'd0;

  function automatic logic [DW-1:0] beat_data(input int idx);
    return 32'h8C30_0000 ^ (32'(idx) * 32'h0012_3457);
  endfunction

  function automatic bit vpat(input bit toggle, input int s);
    return !(toggle && (s < 14) && (s % 2 == 1));
  endfunction

  // state cycle s of a run started at t0 shows its action on inst at sample t0+3+s
  task automatic exp_push(input int t0, input int sa, input int s, input logic [16:0] i,
                          input logic [DW-1:0] m, input bit chk);
    exp_t e;
    if (sa >= 0 && s >= sa) return;
    e.cyc = t0 + 3 + s; e.inst = i; e.mem = m; e.chk = chk;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   eb, er;
    cyc = cyc + 1;
    eb  = (cyc >= bl) && (cyc <= bh);
    er  = (cyc >= rl) && (cyc <= rh);
    checks++;
    if (busy !== eb) begin
      errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
    end
    checks++;
    if (host_ready !== er) begin
      errors++; $display("FAIL host_ready cyc=%0d got=%b exp=%b", cyc, host_ready, er);
    end
    if (!eb) begin
      checks++;
      if (phase !== 4'd0) begin
        errors++; $display("FAIL phase_idle cyc=%0d got=%0d exp=0", cyc, phase);
      end
    end else if (cyc == bl) begin
      checks++;
      if (phase !== 4'd1) begin
        errors++; $display("FAIL phase_qwr cyc=%0d got=%0d exp=1", cyc, phase);
      end
    end else if (cyc == bh) begin
      checks++;
      if (phase !== ph_end) begin
        errors++; $display("FAIL phase_end cyc=%0d got=%0d exp=%0d", cyc, phase, ph_end);
      end
    end
    if (inst !== 17'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL inst_unexpected cyc=%0d got=%05h", cyc, inst);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.inst !== inst || (e.chk && e.mem !== mem_in)) begin
          errors++;
          $display("FAIL inst cyc=%0d got=%05h mem=%08h exp cyc=%0d inst=%05h mem=%08h",
                   cyc, inst, mem_in, e.cyc, e.inst, e.mem);
        end
      end
    end
    if (done !== 1'b0) begin
      checks++;
      if (done_q.size() == 0 || done_q[0] != cyc) begin
        errors++; $display("FAIL done cyc=%0d got=%b exp_cyc=%0d", cyc, done,
                           (done_q.size() == 0) ? -1 : done_q[0]);
      end
      if (done_q.size() != 0) void'(done_q.pop_front());
    end
  end

  // Entered at posedge+1; abort_rel/restart_rel are offsets from the first LOAD cycle (-1 = none)
  task automatic run_seq(input bit toggle, input int abort_rel, input int restart_rel);
    int t0, s, nb, last_add, sk, ld, sa, sr, sdone, send, dn;
    logic [DW-1:0] last_data;
    t0 = cyc; nb = 0; last_add = 0; s = 0; last_data = '0;
    while (nb < TC + COL) begin
      if (vpat(toggle, s)) begin
        last_add  = (nb < TC) ? nb : nb - TC;
        last_data = beat_data(nb);
        exp_push(t0, -1, s, ((nb < TC) ? 17'h00010 : 17'h00004) | 17'(last_add << 12),
                 last_data, 1'b1);
        nb++;
      end else if (last_add != 0) begin
        exp_push(t0, -1, s, 17'(last_add << 12), last_data, 1'b1);
      end
      s++;
    end
    sk = s - 1; ld = s;
    sa = (abort_rel < 0) ? -1 : ld + abort_rel;
    sr = (restart_rel < 0) ? -1 : ld + restart_rel;
`ifdef PMEM_READBACK_EN
    sdone = ld + 54;
`else
    sdone = ld + 46;
`endif
    send = (sa >= 0) ? sa : sdone;
    exp_push(t0, sa, ld, 17'h00040, '0, 1'b0);
    for (int k = 0; k < COL; k++) exp_push(t0, sa, ld + 1 + k, 17'h00048 | 17'(k << 12), '0, 1'b0);
    exp_push(t0, sa, ld + 9, 17'h00040, '0, 1'b0);
    for (int a = 0; a < TC; a++) exp_push(t0, sa, ld + 20 + a, 17'h000A0 | 17'(a << 12), '0, 1'b0);
    for (int a = 0; a < TC; a++) exp_push(t0, sa, ld + 38 + a, 17'h10001 | 17'(a << 8), '0, 1'b0);
`ifdef PMEM_READBACK_EN
    for (int a = 0; a < TC; a++) exp_push(t0, sa, ld + 46 + a, 17'h00002 | 17'(a << 8), '0, 1'b0);
`endif
    if (sa < 0) done_q.push_back(t0 + 2 + sdone);
    bl = t0 + 2; bh = t0 + 2 + send; rl = t0 + 2; rh = t0 + 2 + sk;
    ph_end = (sa >= 0) ? 4'd3 : 4'd10;

    start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; dn = 0;
    for (int i = 0; i <= send; i++) begin
      host_valid = (i <= sk) ? vpat(toggle, i) : 1'b1;
      host_data  = (i <= sk && host_valid) ? beat_data(dn) : 32'hDEAD_BEEF;
      if (i <= sk && host_valid) dn++;
      start = (i == sr);
      abort = (i == sa);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; host_valid = 1'b1;
    for (int w = 0; w < 100 && (exp_q.size() != 0 || done_q.size() != 0); w++) @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got inst_q=%0d done_q=%0d exp 0/0", exp_q.size(), done_q.size());
    end
    exp_q.delete(); done_q.delete();
  endtask

  initial begin
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (inst !== 17'h0 || mem_in !== '0 || busy !== 1'b0 || host_ready !== 1'b0 ||
          phase !== 4'd0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset got inst=%05h mem=%08h busy=%b rdy=%b phase=%0d done=%b exp all 0",
                 inst, mem_in, busy, host_ready, phase, done);
      end
    end
    rst_n = 1'b1; host_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_seq(1'b0, -1, -1);   // host_valid held high
    run_seq(1'b1, -1, -1);   // stalls during QWR
    run_seq(1'b0, -1, 22);   // start re-asserted in EXEC
    run_seq(1'b0, 4, -1);    // abort in LOAD cycle 4
    run_seq(1'b0, -1, -1);   // clean run after abort
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qk_core_sequencer.md
Name: qk_core_sequencer

Overview:
- Per-core instruction sequencer for one fullchip QK core.
- Accepts Q rows and K vectors from a host stream and writes them into qmem/kmem.
- Then runs the fixed sequence: K load into the array, execute, drain ofifo into pmem.
- Drives the 17-bit fullchip inst word and mem_in bus, replacing hand-timed bench stimulus; one instance per core.

Parameters:
- bw, 4, bits per element
- pr, 8, elements per row (mem_in lanes)
- col, 8, K vectors / array columns per core
- total_cycle, 8, Q rows processed per run
- gap, 10, idle cycles after load and after execute (min 1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a run; ignored unless idle
- abort  in  1  synchronous abort; returns to IDLE next cycle
- host_data  in  pr*bw  Q or K row from host
- host_valid  in  1  host_data valid
- host_ready  out  1  sequencer accepts a row this cycle
- mem_in  out  pr*bw  registered data to fullchip mem_in
- inst  out  17  registered fullchip instruction: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- phase  out  4  current state code, for debug

Behaviour:
- Reset (reset=0): state IDLE; inst=0, mem_in=0, host_ready=0, busy=0, done=0, all counters 0. Reset mid-run abandons the run immediately.
- inst and mem_in are registered: an action decided in state S at cycle t appears on inst at cycle t+1.
- States and codes:
  - IDLE 0: start -> QWR.
  - QWR 1: host_ready=1. Each host_valid&host_ready beat n (0..total_cycle-1) produces next cycle qmem_wr=1, qkmem_add=n, mem_in=host_data. With no beat, qmem_wr=0, address and mem_in held. After beat total_cycle-1 -> KWR.
  - KWR 2: same handshake; beats n=0..col-1 give kmem_wr=1, qkmem_add=n. After last beat -> LOAD.
  - LOAD 3: col+1 cycles, load=1 on all. Cycle 0: kmem_rd=0, add=0. Cycles k=1..col: kmem_rd=1, qkmem_add=k-1. Then -> LDRAIN.
  - LDRAIN 4: 1 cycle, load=1, kmem_rd=0, add=0. Then -> GAP1.
  - GAP1 5: gap cycles, inst=0. Then -> EXEC.
  - EXEC 6: total_cycle cycles, execute=1, qmem_rd=1, qkmem_add=0..total_cycle-1. Then -> GAP2.
  - GAP2 7: gap cycles, inst=0. Then -> MOVE.
  - MOVE 8: total_cycle cycles, ofifo_rd=1, pmem_wr=1, pmem_add=0..total_cycle-1. Then -> DONE, or -> RDBK if enabled.
  - DONE 10: one cycle, done=1, inst=0. Then -> IDLE.
- host_ready=0 outside QWR/KWR. A row offered when host_ready=0 is not consumed.
- Address fields are 4 bits. Parameters with total_cycle>16 or col>16 are illegal; the sequencer never wraps an address inside a phase.
- start while busy: ignored, no effect on the running sequence.
- abort (any non-IDLE state): next cycle state=IDLE, inst=0, counters cleared; done not pulsed. abort wins over start in the same cycle.
- The host may hold host_valid high across the QWR->KWR boundary: the beat after the last Q beat is the first K beat.

Optional Feature:
- PMEM_READBACK_EN defined:
  - MOVE -> RDBK (code 9): total_cycle cycles, pmem_rd=1, pmem_add=0..total_cycle-1.
  - Then -> DONE.
- Not defined:
  - No RDBK state.
  - inst[1] is constant 0.
  - MOVE -> DONE directly.

Test Plan:
- Reset held 5 cycles, then released -> inst=0, busy=0, host_ready=0, phase=0 throughout.
- start with host_valid always 1 (defaults) -> 8 qmem_wr beats at addr 0..7, then 8 kmem_wr beats at 0..7 back-to-back; load high 10 cycles; kmem_rd on addr 0..7; 10 idle; execute+qmem_rd 8 cycles at addr 0..7; 10 idle; ofifo_rd+pmem_wr at pmem_add 0..7; done pulses once.
- host_valid toggled 1,0,1,0 during QWR -> qmem_wr only on accepted beats; qkmem_add holds across stall cycles; still exactly 8 Q writes with correct data per address.
- start re-asserted during EXEC -> no restart, sequence unchanged, single done pulse.
- abort during LOAD at cycle 4 -> next cycle inst=0, phase=0, busy=0, no done. A new start then runs a full clean sequence.
- Build with PMEM_READBACK_EN -> after MOVE, 8 cycles pmem_rd=1 at pmem_add 0..7, then done. Build without -> inst[1] never set.
